// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
// Holds the FSM state enum, width defaults and a saturating increment.
package mem_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 4;
  localparam int PERF_W     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Word-addressed storage: synchronous write, asynchronous read, no reset.
module mem_responder_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder with request/response valid-ready handshakes.
// Optional MEM_RESP_PERF_EN adds saturating rd_count/wr_count outputs.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_wr,
  output logic [DATA_W-1:0] resp_rdata
`ifdef MEM_RESP_PERF_EN
  ,
  output logic [PERF_W-1:0] rd_count,
  output logic [PERF_W-1:0] wr_count
`endif
);

  generate
    if (LATENCY < 1 || LATENCY > (1 << CNT_W) - 1) begin : g_bad_latency
      $error("mem_responder: LATENCY must be within 1..15");
    end
  endgenerate

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic              resp_wr_q;
  logic [DATA_W-1:0] resp_rdata_q;

  logic              accept;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_rdata;

  // The write commits on the acceptance edge, so a later read sees it.
  assign accept   = req_valid && req_ready_q;
  assign arr_we   = accept && req_wr;
  assign arr_addr = req_ready_q ? req_addr : addr_q;

  mem_responder_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (req_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_wr_q    <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q     <= WAIT;
            req_ready_q <= 1'b0;
            cnt_q       <= CNT_W'(LATENCY - 1);
            wr_q        <= req_wr;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_wr_q    <= wr_q;
            resp_rdata_q <= wr_q ? wdata_q : arr_rdata;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_wr    = resp_wr_q;
  assign resp_rdata = resp_rdata_q;

`ifdef MEM_RESP_PERF_EN
  logic [PERF_W-1:0] rd_cnt_q;
  logic [PERF_W-1:0] wr_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (accept) begin
      if (req_wr) begin
        wr_cnt_q <= sat_inc(wr_cnt_q);
      end else begin
        rd_cnt_q <= sat_inc(rd_cnt_q);
      end
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: two responders (LATENCY 3 and 1) checked against an array model.
module tb_mem_responder;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int L0 = 3;
  localparam int L1 = 1;

  logic          clk;
  logic          rst_n;

  logic          a_req_valid, a_req_ready, a_req_wr;
  logic [AW-1:0] a_req_addr;
  logic [DW-1:0] a_req_wdata;
  logic          a_resp_valid, a_resp_ready, a_resp_wr;
  logic [DW-1:0] a_resp_rdata;

  logic          b_req_valid, b_req_ready, b_req_wr;
  logic [AW-1:0] b_req_addr;
  logic [DW-1:0] b_req_wdata;
  logic          b_resp_valid, b_resp_ready, b_resp_wr;
  logic [DW-1:0] b_resp_rdata;

`ifdef MEM_RESP_PERF_EN
  logic [15:0]   a_rd_count, a_wr_count, b_rd_count, b_wr_count;
`endif

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] model   [32];
  logic [DW-1:0] b_model [32];
  int            exp_rd = 0;
  int            exp_wr = 0;

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(L0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (a_req_valid),
    .req_ready  (a_req_ready),
    .req_wr     (a_req_wr),
    .req_addr   (a_req_addr),
    .req_wdata  (a_req_wdata),
    .resp_valid (a_resp_valid),
    .resp_ready (a_resp_ready),
    .resp_wr    (a_resp_wr),
    .resp_rdata (a_resp_rdata)
`ifdef MEM_RESP_PERF_EN
    ,
    .rd_count   (a_rd_count),
    .wr_count   (a_wr_count)
`endif
  );

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(L1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (b_req_valid),
    .req_ready  (b_req_ready),
    .req_wr     (b_req_wr),
    .req_addr   (b_req_addr),
    .req_wdata  (b_req_wdata),
    .resp_valid (b_resp_valid),
    .resp_ready (b_resp_ready),
    .resp_wr    (b_resp_wr),
    .resp_rdata (b_resp_rdata)
`ifdef MEM_RESP_PERF_EN
    ,
    .rd_count   (b_rd_count),
    .wr_count   (b_wr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction on the LATENCY=3 instance; called and returns at a falling edge.
  task automatic a_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input string tag);
    logic [DW-1:0] exp;
    int k;
    chk({tag, "/req_ready"}, {31'd0, a_req_ready}, 32'd1);
    a_req_valid  = 1'b1;
    a_req_wr     = wr;
    a_req_addr   = addr;
    a_req_wdata  = wdata;
    a_resp_ready = 1'b1;
    if (wr) begin
      model[addr] = wdata;
      exp = wdata;
      exp_wr++;
    end else begin
      exp = model[addr];
      exp_rd++;
    end
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    a_req_wr    = 1'($urandom);
    a_req_addr  = 5'($urandom);
    a_req_wdata = $urandom;
    k = 0;
    while (!a_resp_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "/latency"}, 32'(k), 32'(L0));
    chk({tag, "/resp_wr"}, {31'd0, a_resp_wr}, {31'd0, wr});
    chk({tag, "/rdata"}, a_resp_rdata, exp);
    @(negedge clk);
    chk({tag, "/done_valid"}, {31'd0, a_resp_valid}, 32'd0);
    chk({tag, "/done_ready"}, {31'd0, a_req_ready}, 32'd1);
  endtask

  // Transaction on the LATENCY=1 instance; keep_valid leaves req_valid asserted while busy.
  task automatic b_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input logic keep_valid, input string tag);
    logic [DW-1:0] exp;
    int low;
    int got;
    chk({tag, "/req_ready"}, {31'd0, b_req_ready}, 32'd1);
    b_req_valid = 1'b1;
    b_req_wr    = wr;
    b_req_addr  = addr;
    b_req_wdata = wdata;
    if (wr) begin
      b_model[addr] = wdata;
      exp = wdata;
    end else begin
      exp = b_model[addr];
    end
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) b_req_valid = 1'b0;
    low = 0;
    got = 0;
    while (!b_req_ready && low < 40) begin
      if (b_resp_valid) begin
        chk({tag, "/rdata"}, b_resp_rdata, exp);
        got++;
      end
      low++;
      @(negedge clk);
    end
    chk({tag, "/busy_cycles"}, 32'(low), 32'd2);
    chk({tag, "/resp_seen"}, 32'(got), 32'd1);
  endtask

  initial begin
    logic [DW-1:0] bp_exp;
    int k;

    rst_n = 1'b0;
    a_req_valid = 1'b0; a_req_wr = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_resp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_wr = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst/req_ready", {31'd0, a_req_ready}, 32'd1);
    chk("rst/resp_valid", {31'd0, a_resp_valid}, 32'd0);
    chk("rst/resp_wr", {31'd0, a_resp_wr}, 32'd0);
    chk("rst/resp_rdata", a_resp_rdata, 32'd0);
`ifdef MEM_RESP_PERF_EN
    chk("rst/rd_count", {16'd0, a_rd_count}, 32'd0);
    chk("rst/wr_count", {16'd0, a_wr_count}, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    a_txn(1'b1, 5'd5, 32'hDEADBEEF, "w5");
    a_txn(1'b0, 5'd5, 32'd0, "r5");
    chk("r5/const", a_resp_rdata, 32'hDEADBEEF);

    for (int i = 0; i < 32; i++) a_txn(1'b1, 5'(i), $urandom, $sformatf("init%0d", i));
    for (int i = 0; i < 40; i++)
      a_txn(1'($urandom_range(0, 1)), 5'($urandom), $urandom, $sformatf("rnd%0d", i));

    // Backpressure on a read of addr 3, with a competing request that must be ignored.
    a_req_valid = 1'b1; a_req_wr = 1'b0; a_req_addr = 5'd3; a_resp_ready = 1'b0;
    bp_exp = model[3];
    exp_rd++;
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    k = 0;
    while (!a_resp_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("bp/latency", 32'(k), 32'(L0));
    for (int i = 0; i < 10; i++) begin
      a_req_valid = 1'b1; a_req_wr = 1'b1; a_req_addr = 5'd3; a_req_wdata = ~bp_exp;
      @(negedge clk);
      chk($sformatf("bp%0d/valid", i), {31'd0, a_resp_valid}, 32'd1);
      chk($sformatf("bp%0d/rdata", i), a_resp_rdata, bp_exp);
      chk($sformatf("bp%0d/req_ready", i), {31'd0, a_req_ready}, 32'd0);
    end
    a_req_valid = 1'b0;
    a_resp_ready = 1'b1;
    @(negedge clk);
    chk("bp/done_valid", {31'd0, a_resp_valid}, 32'd0);
    chk("bp/done_ready", {31'd0, a_req_ready}, 32'd1);
    a_txn(1'b0, 5'd3, 32'd0, "bp_reread");

    // Reset while a write to addr 7 is waiting.
    a_req_valid = 1'b1; a_req_wr = 1'b1; a_req_addr = 5'd7; a_req_wdata = 32'h12345678;
    model[7] = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst/resp_valid", {31'd0, a_resp_valid}, 32'd0);
    chk("mid_rst/req_ready", {31'd0, a_req_ready}, 32'd1);
    exp_rd = 0;
    exp_wr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < L0 + 2; i++) begin
      @(negedge clk);
      chk($sformatf("mid_rst/no_resp%0d", i), {31'd0, a_resp_valid}, 32'd0);
    end
    a_txn(1'b0, 5'd7, 32'd0, "mid_rst/r7");
    chk("mid_rst/r7_const", a_resp_rdata, 32'h12345678);

    a_txn(1'b1, 5'd31, 32'hFFFFFFFF, "w31");
    a_txn(1'b1, 5'd0, 32'h00000001, "w0");
    a_txn(1'b0, 5'd31, 32'd0, "r31");
    chk("r31/const", a_resp_rdata, 32'hFFFFFFFF);
    a_txn(1'b0, 5'd0, 32'd0, "r0");
    chk("r0/const", a_resp_rdata, 32'h00000001);

`ifdef MEM_RESP_PERF_EN
    chk("perf/rd_count", {16'd0, a_rd_count}, 32'(exp_rd));
    chk("perf/wr_count", {16'd0, a_wr_count}, 32'(exp_wr));
    force dut.rd_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.rd_cnt_q;
    a_txn(1'b0, 5'd0, 32'd0, "perf/sat_read");
    chk("perf/rd_sat", {16'd0, a_rd_count}, 32'h0000FFFF);
`endif

    // LATENCY=1 instance: writes, then back-to-back reads with req_valid held.
    b_txn(1'b1, 5'd0, $urandom, 1'b0, "b_w0");
    b_txn(1'b1, 5'd31, $urandom, 1'b0, "b_w31");
    b_txn(1'b0, 5'd0, 32'd0, 1'b1, "b_r0");
    b_txn(1'b0, 5'd31, 32'd0, 1'b0, "b_r31");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the cache's refill and write-through traffic. It accepts one request at a time over a valid/ready handshake and serves it from a word-addressed storage array after a fixed, parameterised latency. It returns read data, or a write acknowledge, over a second valid/ready handshake. It sits between the cache controller (initiator) and backing storage, and replaces the zero-latency combinational RAM path.

## Interface
- ADDR_W, default 5, word address width; storage depth is 2**ADDR_W words
- DATA_W, default 32, data word width
- LATENCY, default 3, cycles from request acceptance to resp_valid; legal range 1..15
- clk  in  1  single clock, all state updates on its rising edge
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  1  initiator has a request
- req_ready  out  1  responder can accept; high only in IDLE
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data; ignored for reads
- resp_valid  out  1  response available
- resp_ready  in  1  initiator takes the response
- resp_wr  out  1  echo of req_wr for the response
- resp_rdata  out  DATA_W  read data; for writes, echo of the written data

## Operation
- FSM states:
  - IDLE: req_ready=1.
  - WAIT: latency countdown.
  - RESP: resp_valid=1.
- IDLE -> WAIT on an edge where req_valid && req_ready.
  - That edge captures req_wr, req_addr and req_wdata.
  - That edge loads cnt = LATENCY-1.
  - For writes, that edge also writes req_wdata into array[req_addr].
- WAIT, cnt != 0: decrement cnt.
- WAIT -> RESP when cnt == 0:
  - Reads load resp_rdata from array[captured addr].
  - Writes load resp_rdata with the captured wdata.
- RESP -> IDLE on an edge where resp_valid && resp_ready.
  - resp_rdata and resp_wr hold their values until that edge, regardless of inputs.
- While not in IDLE, req_valid is ignored. The request is not accepted and the initiator must hold it.
- Read-after-write: a read accepted after a write's acceptance edge returns the new data.
- cnt is 4 bits unsigned and never wraps; LATENCY outside 1..15 is a synthesis-time error.
- Storage array has no reset; contents are undefined until written.

## Timing
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_wr=0, resp_rdata=0, cnt=0.
- Reset asserted mid-transaction:
  - FSM returns to IDLE immediately and the in-flight response is dropped.
  - A write already committed at acceptance stays in the array.
- Latency: acceptance at edge E gives resp_valid=1 in the cycle after edge E+LATENCY.
- resp_ready held high:
  - Response completes at edge E+LATENCY+1.
  - req_ready is high again in the following cycle.
  - Minimum request-to-request spacing is LATENCY+2 cycles.
- resp_ready already high when resp_valid rises: handshake completes on the first RESP edge.
- req_valid and resp_ready have no combinational path to any output.

## Configuration
- MEM_RESP_PERF_EN defined: adds outputs rd_count and wr_count.
  - Both are 16-bit, saturating at 16'hFFFF.
  - Each increments on an accepted read or write respectively.
  - Both reset to 0 with rst_n.
- MEM_RESP_PERF_EN undefined: the ports and counters are absent and all other behaviour is identical.

## Structure
- Shared package mem_pkg:
  - ADDR_W/DATA_W defaults
  - state enum (IDLE, WAIT, RESP)
  - counter width constant
- Sub-module mem_responder_array: synchronous-write, asynchronous-read storage with ports clk, we, addr, wdata, rdata. The FSM and handshake logic stay in mem_responder.

## Test plan
- Reset, then write addr 5 = 32'hDEADBEEF, then read addr 5.
  - Write response has resp_wr=1 and resp_rdata=32'hDEADBEEF.
  - Read returns 32'hDEADBEEF exactly LATENCY cycles after acceptance.
- LATENCY=1, back-to-back reads of addr 0 and addr 31 with resp_ready tied high.
  - Correct data for each.
  - req_ready low for exactly 2 cycles per transaction.
- Backpressure: resp_ready held low 10 cycles during a read of addr 3.
  - resp_valid and resp_rdata stable throughout.
  - req_ready stays low and a new req_valid is not accepted.
- Reset asserted in WAIT of a write to addr 7 = 32'h12345678.
  - No response.
  - req_ready=1 right after reset.
  - A subsequent read of addr 7 returns 32'h12345678.
- Write addr 31 = 32'hFFFFFFFF, then write addr 0 = 32'h1, then read both.
  - Top address is reached with no aliasing.
  - Reads return FFFFFFFF and 00000001.
- MEM_RESP_PERF_EN: 3 reads and 2 writes.
  - rd_count=3 and wr_count=2.
  - Forcing rd_count to 16'hFFFF and issuing one more read leaves it at FFFF.
